// File: rtl/schmidl_cox_pkg.sv
// Shared types and default widths for the Schmidl-Cox frame sequencer.
package schmidl_cox_pkg;

  localparam int DEF_ITEM_W     = 32;
  localparam int DEF_PKT_SIZE_W = 16;
  localparam int DEF_HOLDOFF_W  = 16;
  localparam int DEF_IDX_W      = 32;

  typedef enum logic [1:0] {
    SEL_ZERO      = 2'd0,
    SEL_FRAME     = 2'd1,
    SEL_FRAME_IDX = 2'd2,
    SEL_BYPASS    = 2'd3
  } output_select_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FRAME   = 2'd1,
    INDEX   = 2'd2,
    HOLDOFF = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/schmidl_cox_frame_ctrl_if.sv
// Sample stream channel (tdata/tuser/tlast with valid/ready) used on both sides of the sequencer.
interface schmidl_cox_frame_ctrl_if
  import schmidl_cox_pkg::*;
#(
  parameter int ITEM_W = DEF_ITEM_W
) ();
  logic [ITEM_W-1:0] tdata;
  logic              tuser;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/schmidl_cox_out_reg.sv
// Single-stage AXIS output register; accepts a new item whenever the held one drains or is absent.
module schmidl_cox_out_reg
  import schmidl_cox_pkg::*;
#(
  parameter int ITEM_W = DEF_ITEM_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vld_p0,
  input  logic [ITEM_W-1:0]        data_p0,
  input  logic                     last_p0,
  output logic                     rdy_p0,
  schmidl_cox_frame_ctrl_if.master m_axis
);

  logic              vld_p1;
  logic              last_p1;
  logic [ITEM_W-1:0] data_p1;

  assign rdy_p0 = m_axis.tready | ~vld_p1;

  // p0 -> p1: output register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      data_p1 <= '0;
    end else if (rdy_p0) begin
      vld_p1  <= vld_p0;
      last_p1 <= vld_p0 & last_p0;
      if (vld_p0) begin
        data_p1 <= data_p0;
      end
    end
  end

  assign m_axis.tvalid = vld_p1;
  assign m_axis.tlast  = last_p1;
  assign m_axis.tdata  = data_p1;
  assign m_axis.tuser  = 1'b0;

endmodule

// File: rtl/schmidl_cox_frame_ctrl.sv
// Gates one frame of cfg_packet_size samples per detection, with holdoff and optional index word.
// Define SCHMIDL_COX_FRAME_CTRL_STATS_EN to add saturating stat_frames/stat_missed counters.
module schmidl_cox_frame_ctrl
  import schmidl_cox_pkg::*;
#(
  parameter int ITEM_W     = DEF_ITEM_W,
  parameter int PKT_SIZE_W = DEF_PKT_SIZE_W,
  parameter int HOLDOFF_W  = DEF_HOLDOFF_W,
  parameter int IDX_W      = DEF_IDX_W
) (
  input  logic                     ce_clk,
  input  logic                     ce_rst_n,
  input  logic [PKT_SIZE_W-1:0]    cfg_packet_size,
  input  logic [HOLDOFF_W-1:0]     cfg_holdoff,
  input  logic [1:0]               cfg_output_select,
  schmidl_cox_frame_ctrl_if.slave  s_axis,
  schmidl_cox_frame_ctrl_if.master m_axis,
  output logic                     busy,
  output logic                     det_missed
`ifdef SCHMIDL_COX_FRAME_CTRL_STATS_EN
  ,
  output logic [31:0]              stat_frames,
  output logic [31:0]              stat_missed
`endif
);

  localparam logic [1:0] ST_IDLE    = 2'(IDLE);
  localparam logic [1:0] ST_FRAME   = 2'(FRAME);
  localparam logic [1:0] ST_INDEX   = 2'(INDEX);
  localparam logic [1:0] ST_HOLDOFF = 2'(HOLDOFF);

  logic [1:0]            state;
  output_select_e        sel_live;
  output_select_e        sel_lat;
  logic [PKT_SIZE_W-1:0] size_live;
  logic [PKT_SIZE_W-1:0] pkt_lat;
  logic [HOLDOFF_W-1:0]  hold_lat;
  logic [PKT_SIZE_W-1:0] frame_cnt;
  logic [PKT_SIZE_W-1:0] frame_cnt_inc;
  logic [PKT_SIZE_W-1:0] byp_cnt;
  logic [PKT_SIZE_W:0]   byp_cnt_inc;
  logic [HOLDOFF_W-1:0]  hold_cnt;
  logic [HOLDOFF_W-1:0]  hold_cnt_inc;
  logic [IDX_W-1:0]      sample_idx;
  logic [IDX_W-1:0]      det_idx;

  logic                  s_rdy;
  logic                  s_hs;
  logic                  out_rdy;
  logic                  fwd;
  logic                  fwd_zero;
  logic                  fwd_last;
  logic                  start_frame;
  logic                  det_hit;
  logic                  byp;
  logic                  frame_done;
  logic                  hold_done;

  logic                  vld_p0;
  logic                  last_p0;
  logic [ITEM_W-1:0]     data_p0;

  logic                  unused_ok;
  assign unused_ok = s_axis.tlast;

  function automatic logic [1:0] after_frame(input output_select_e sel,
                                             input logic [HOLDOFF_W-1:0] hold);
    if (sel == SEL_FRAME_IDX) return ST_INDEX;
    return (hold != '0) ? ST_HOLDOFF : ST_IDLE;
  endfunction

  assign sel_live      = output_select_e'(cfg_output_select);
  assign size_live     = (cfg_packet_size == '0) ? PKT_SIZE_W'(1) : cfg_packet_size;
  assign frame_cnt_inc = frame_cnt + PKT_SIZE_W'(1);
  assign byp_cnt_inc   = {1'b0, byp_cnt} + (PKT_SIZE_W + 1)'(1);
  assign hold_cnt_inc  = hold_cnt + HOLDOFF_W'(1);
  assign frame_done    = (frame_cnt_inc == pkt_lat);
  assign hold_done     = (hold_cnt_inc == hold_lat);

  // Samples that will be dropped are taken regardless of output backpressure.
  always_comb begin
    s_rdy       = 1'b0;
    fwd         = 1'b0;
    fwd_zero    = 1'b0;
    fwd_last    = 1'b0;
    start_frame = 1'b0;
    det_hit     = 1'b0;
    byp         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel_live == SEL_BYPASS) begin
          s_rdy    = out_rdy;
          fwd      = 1'b1;
          byp      = 1'b1;
          fwd_last = (byp_cnt_inc >= {1'b0, size_live});
        end else if (s_axis.tuser) begin
          s_rdy       = out_rdy;
          fwd         = 1'b1;
          start_frame = 1'b1;
          fwd_last    = (size_live == PKT_SIZE_W'(1)) && (sel_live != SEL_FRAME_IDX);
        end else if (sel_live == SEL_ZERO) begin
          s_rdy    = out_rdy;
          fwd      = 1'b1;
          fwd_zero = 1'b1;
        end else begin
          s_rdy = 1'b1;
        end
      end
      ST_FRAME: begin
        s_rdy    = out_rdy;
        fwd      = 1'b1;
        det_hit  = s_axis.tuser;
        fwd_last = frame_done && (sel_lat != SEL_FRAME_IDX);
      end
      ST_HOLDOFF: begin
        det_hit = s_axis.tuser;
        if (sel_lat == SEL_ZERO) begin
          s_rdy    = out_rdy;
          fwd      = 1'b1;
          fwd_zero = 1'b1;
        end else begin
          s_rdy = 1'b1;
        end
      end
      default: begin
        s_rdy = 1'b0;
      end
    endcase
  end

  assign s_hs          = s_axis.tvalid & s_rdy;
  assign s_axis.tready = s_rdy;

  // p0: item presented to the output register
  always_comb begin
    if (state == ST_INDEX) begin
      vld_p0  = 1'b1;
      data_p0 = ITEM_W'(det_idx);
      last_p0 = 1'b1;
    end else begin
      vld_p0  = s_hs & fwd;
      data_p0 = fwd_zero ? '0 : s_axis.tdata;
      last_p0 = fwd_last;
    end
  end

  always_ff @(posedge ce_clk) begin
    if (!ce_rst_n) begin
      state      <= ST_IDLE;
      sel_lat    <= SEL_ZERO;
      pkt_lat    <= '0;
      hold_lat   <= '0;
      frame_cnt  <= '0;
      byp_cnt    <= '0;
      hold_cnt   <= '0;
      sample_idx <= '0;
      det_idx    <= '0;
      det_missed <= 1'b0;
    end else begin
      det_missed <= s_hs & det_hit;
      if (s_hs) begin
        sample_idx <= sample_idx + IDX_W'(1);
      end
      case (state)
        ST_IDLE: begin
          if (s_hs) begin
            byp_cnt <= (byp && !fwd_last) ? byp_cnt_inc[PKT_SIZE_W-1:0] : '0;
            if (start_frame) begin
              sel_lat   <= sel_live;
              pkt_lat   <= size_live;
              hold_lat  <= cfg_holdoff;
              det_idx   <= sample_idx;
              frame_cnt <= PKT_SIZE_W'(1);
              hold_cnt  <= '0;
              state     <= (size_live == PKT_SIZE_W'(1)) ? after_frame(sel_live, cfg_holdoff)
                                                          : ST_FRAME;
            end
          end
        end
        ST_FRAME: begin
          if (s_hs) begin
            frame_cnt <= frame_cnt_inc;
            if (frame_done) begin
              state <= after_frame(sel_lat, hold_lat);
            end
          end
        end
        ST_INDEX: begin
          if (out_rdy) begin
            state <= (hold_lat != '0) ? ST_HOLDOFF : ST_IDLE;
          end
        end
        default: begin
          if (s_hs) begin
            hold_cnt <= hold_cnt_inc;
            if (hold_done) begin
              state <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

  schmidl_cox_out_reg #(
    .ITEM_W (ITEM_W)
  ) u_out_reg (
    .clk     (ce_clk),
    .rst_n   (ce_rst_n),
    .vld_p0  (vld_p0),
    .data_p0 (data_p0),
    .last_p0 (last_p0),
    .rdy_p0  (out_rdy),
    .m_axis  (m_axis)
  );

`ifdef SCHMIDL_COX_FRAME_CTRL_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge ce_clk) begin
    if (!ce_rst_n) begin
      stat_frames <= '0;
      stat_missed <= '0;
    end else begin
      if (m_axis.tvalid && m_axis.tready && m_axis.tlast) begin
        stat_frames <= sat_inc(stat_frames);
      end
      if (det_missed) begin
        stat_missed <= sat_inc(stat_missed);
      end
    end
  end
`endif

endmodule

// File: tb/tb_schmidl_cox_frame_ctrl.sv
// Bench for schmidl_cox_frame_ctrl: directed and random streams against a segment-level reference model.
`timescale 1ns/1ps
module tb_schmidl_cox_frame_ctrl;
  import schmidl_cox_pkg::*;

  localparam int ITEM_W     = 32;
  localparam int PKT_SIZE_W = 16;
  localparam int HOLDOFF_W  = 16;
  localparam int IDX_W      = 32;

  logic                  ce_clk = 1'b0;
  logic                  ce_rst_n = 1'b0;
  logic [PKT_SIZE_W-1:0] cfg_packet_size = '0;
  logic [HOLDOFF_W-1:0]  cfg_holdoff = '0;
  logic [1:0]            cfg_output_select = '0;
  logic                  busy;
  logic                  det_missed;
  bit                    bp_en = 1'b0;

  schmidl_cox_frame_ctrl_if #(.ITEM_W(ITEM_W)) s_axis ();
  schmidl_cox_frame_ctrl_if #(.ITEM_W(ITEM_W)) m_axis ();

  schmidl_cox_frame_ctrl #(
    .ITEM_W     (ITEM_W),
    .PKT_SIZE_W (PKT_SIZE_W),
    .HOLDOFF_W  (HOLDOFF_W),
    .IDX_W      (IDX_W)
  ) dut (
    .ce_clk            (ce_clk),
    .ce_rst_n          (ce_rst_n),
    .cfg_packet_size   (cfg_packet_size),
    .cfg_holdoff       (cfg_holdoff),
    .cfg_output_select (cfg_output_select),
    .s_axis            (s_axis),
    .m_axis            (m_axis),
    .busy              (busy),
    .det_missed        (det_missed)
  );

  always #5 ce_clk = ~ce_clk;

  always @(posedge ce_clk) begin
    #1;
    m_axis.tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic [31:0] got_d[$];
  logic        got_l[$];
  int          miss_obs = 0;

  always @(negedge ce_clk) begin
    if (m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1) begin
      got_d.push_back(m_axis.tdata);
      got_l.push_back(m_axis.tlast);
    end
    if (det_missed === 1'b1) miss_obs++;
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] in_d[$];
  logic        in_u[$];
  logic [31:0] exp_d[$];
  logic        exp_l[$];
  int          exp_miss;
  int          got_base;
  int          miss_base;
  int          r_sel, r_pkt, r_hold, n_got;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    ce_rst_n = 1'b0;
    s_axis.tvalid = 1'b0;
    s_axis.tuser  = 1'b0;
    s_axis.tlast  = 1'b0;
    s_axis.tdata  = '0;
    repeat (2) @(posedge ce_clk);
    #1;
    ce_rst_n = 1'b1;
  endtask

  task automatic set_cfg(input int sel, input int pkt, input int hold);
    cfg_output_select = 2'(sel);
    cfg_packet_size   = PKT_SIZE_W'(pkt);
    cfg_holdoff       = HOLDOFF_W'(hold);
  endtask

  task automatic send(input logic [31:0] d, input logic u);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    s_axis.tdata  = d;
    s_axis.tuser  = u;
    s_axis.tvalid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge ce_clk);
      acc = (s_axis.tready === 1'b1);
      n++;
      @(posedge ce_clk);
      #1;
    end
    s_axis.tvalid = 1'b0;
    s_axis.tuser  = 1'b0;
    check("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic build_ramp(input int n);
    in_d.delete();
    in_u.delete();
    for (int i = 0; i < n; i++) begin
      in_d.push_back(32'(i));
      in_u.push_back(1'b0);
    end
  endtask

  // Frame/holdoff segments computed directly from the detection positions.
  task automatic model(input int sel, input int pkt_cfg, input int hold);
    int pkt, p, n, bcnt, start, k;
    pkt  = (pkt_cfg == 0) ? 1 : pkt_cfg;
    n    = in_d.size();
    p    = 0;
    bcnt = 0;
    exp_d.delete();
    exp_l.delete();
    exp_miss = 0;
    while (p < n) begin
      if (sel == 3) begin
        bcnt++;
        exp_d.push_back(in_d[p]);
        exp_l.push_back((bcnt % pkt) == 0);
        p++;
      end else if (in_u[p]) begin
        start = p;
        k     = 0;
        while (k < pkt && p < n) begin
          if (k > 0 && in_u[p]) exp_miss++;
          exp_d.push_back(in_d[p]);
          exp_l.push_back(k == pkt - 1 && sel != 2);
          k++;
          p++;
        end
        if (k == pkt) begin
          if (sel == 2) begin
            exp_d.push_back(32'(start));
            exp_l.push_back(1'b1);
          end
          for (int h = 0; h < hold && p < n; h++) begin
            if (in_u[p]) exp_miss++;
            if (sel == 0) begin
              exp_d.push_back(32'd0);
              exp_l.push_back(1'b0);
            end
            p++;
          end
        end
      end else begin
        if (sel == 0) begin
          exp_d.push_back(32'd0);
          exp_l.push_back(1'b0);
        end
        p++;
      end
    end
  endtask

  task automatic mark();
    got_base  = got_d.size();
    miss_base = miss_obs;
  endtask

  task automatic drain();
    bp_en = 1'b0;
    repeat (8) @(posedge ce_clk);
    #1;
  endtask

  task automatic play();
    for (int i = 0; i < in_d.size(); i++) send(in_d[i], in_u[i]);
    drain();
  endtask

  task automatic compare(input string name);
    int ng;
    ng = got_d.size() - got_base;
    check({name, "_count"}, 32'(ng), 32'(exp_d.size()));
    for (int i = 0; i < ng && i < exp_d.size(); i++) begin
      check({name, "_data"}, got_d[got_base + i], exp_d[i]);
      check({name, "_last"}, 32'(got_l[got_base + i]), 32'(exp_l[i]));
    end
    check({name, "_missed"}, 32'(miss_obs - miss_base), 32'(exp_miss));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    set_cfg(1, 4, 0);
    do_reset();
    check("rst_tvalid", 32'(m_axis.tvalid), 32'd0);
    check("rst_tlast", 32'(m_axis.tlast), 32'd0);
    check("rst_tdata", m_axis.tdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_missed", 32'(det_missed), 32'd0);

    // Frame-only, single detection on sample 10
    build_ramp(31);
    in_u[10] = 1'b1;
    model(1, 4, 0);
    mark();
    for (int i = 0; i < in_d.size(); i++) begin
      send(in_d[i], in_u[i]);
      if (i == 10) check("t1_busy_in_frame", 32'(busy), 32'd1);
    end
    drain();
    compare("t1");
    check("t1_busy_after", 32'(busy), 32'd0);

    // Frame plus trailing index word
    set_cfg(2, 3, 0);
    do_reset();
    build_ramp(106);
    in_u[100] = 1'b1;
    model(2, 3, 0);
    mark();
    play();
    compare("t2");

    // Holdoff with missed detections, including one on the exiting sample
    set_cfg(1, 4, 5);
    do_reset();
    build_ramp(25);
    in_u[10] = 1'b1;
    in_u[12] = 1'b1;
    in_u[16] = 1'b1;
    in_u[18] = 1'b1;
    in_u[19] = 1'b1;
    model(1, 4, 5);
    mark();
    play();
    compare("t3");

    // Zero-fill without detection
    set_cfg(0, 4, 0);
    do_reset();
    build_ramp(8);
    for (int i = 0; i < 8; i++) in_d[i] = 32'hA500_0000 + 32'(i);
    model(0, 4, 0);
    mark();
    play();
    compare("t4");

    // Bypass with periodic tlast
    set_cfg(3, 5, 0);
    do_reset();
    build_ramp(12);
    model(3, 5, 0);
    mark();
    play();
    compare("t5");

    // Reset in the middle of a frame under random backpressure
    set_cfg(1, 6, 0);
    do_reset();
    mark();
    bp_en = 1'b1;
    send(32'd0, 1'b0);
    send(32'd1, 1'b0);
    send(32'd2, 1'b1);
    send(32'd3, 1'b0);
    send(32'd4, 1'b0);
    check("t6_busy_mid", 32'(busy), 32'd1);
    ce_rst_n = 1'b0;
    @(posedge ce_clk);
    #1;
    ce_rst_n = 1'b1;
    check("t6_tvalid_after_rst", 32'(m_axis.tvalid), 32'd0);
    check("t6_busy_after_rst", 32'(busy), 32'd0);
    n_got = got_d.size() - got_base;
    check("t6_prefix_len", 32'(n_got == 2 || n_got == 3), 32'd1);
    for (int i = 0; i < n_got; i++) begin
      check("t6_prefix_data", got_d[got_base + i], 32'(2 + i));
      check("t6_prefix_last", 32'(got_l[got_base + i]), 32'd0);
    end
    build_ramp(12);
    in_u[3] = 1'b1;
    model(1, 6, 0);
    mark();
    bp_en = 1'b1;
    play();
    compare("t6_post");

    // Random configurations and streams under backpressure
    for (int t = 0; t < 6; t++) begin
      r_sel  = $urandom_range(0, 3);
      r_pkt  = $urandom_range(0, 6);
      r_hold = $urandom_range(0, 4);
      set_cfg(r_sel, r_pkt, r_hold);
      do_reset();
      in_d.delete();
      in_u.delete();
      for (int i = 0; i < 40; i++) begin
        in_d.push_back($urandom);
        in_u.push_back($urandom_range(0, 5) == 0);
      end
      model(r_sel, r_pkt, r_hold);
      mark();
      bp_en = 1'b1;
      play();
      compare("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/schmidl_cox_frame_ctrl.md
Name: schmidl_cox_frame_ctrl

Overview:
- Sequencer between the Schmidl-Cox timing metric/detector and the CHDR output packetizer inside rfnoc_block_schmidl_cox, in the ce_clk domain.
- Watches the sample stream and its per-sample detection flag, then gates out exactly one frame of cfg_packet_size samples per detection.
- Applies the output-select mode, a post-frame holdoff, and an optional trailing index word.

Parameters:
- ITEM_W, 32, sample width (sc16 I/Q).
- PKT_SIZE_W, 16, width of cfg_packet_size.
- HOLDOFF_W, 16, width of cfg_holdoff.
- IDX_W, 32, width of the free-running sample index.

Ports:
- ce_clk  in  1  block clock.
- ce_rst_n  in  1  reset; synchronous, active-low.
- cfg_packet_size  in  PKT_SIZE_W  frame length in samples; 0 is treated as 1.
- cfg_holdoff  in  HOLDOFF_W  samples ignored for detection after a frame ends.
- cfg_output_select  in  2  0=zero-fill, 1=frame-only, 2=frame+index, 3=bypass.
- s_axis_tdata  in  ITEM_W  input sample.
- s_axis_tuser  in  1  detection flag aligned to this sample.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  ITEM_W  output sample.
- m_axis_tlast  out  1  end of frame.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- busy  out  1  high while in FRAME, INDEX or HOLDOFF.
- det_missed  out  1  one-cycle pulse when a detection arrives in FRAME or HOLDOFF.

Behaviour:
- Reset (ce_rst_n=0 at a ce_clk edge): state=IDLE, all counters 0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, det_missed=0. Reset mid-frame discards the frame silently; no tlast is emitted.
- Handshake and latency:
  - Output is a single registered stage; latency is 1 cycle.
  - s_axis_tready = m_axis_tready OR NOT m_axis_tvalid (skid-free pipeline). In INDEX state s_axis_tready=0.
  - Dropped samples are accepted with s_axis_tready=1 regardless of output backpressure.
- Sample index: sample_idx increments on every input handshake and wraps modulo 2^IDX_W.
- Config latch: cfg_* is sampled on the handshake that enters FRAME. Changes mid-frame have no effect until the next frame.
- State IDLE:
  - select 0: forward the sample with tdata=0, tlast=0.
  - select 1 or 2: drop the sample.
  - select 3: bypass raw; tlast is asserted every latched packet_size samples by a free-running counter, and no other state is entered.
  - Handshake with tuser=1 (select≠3): that sample is the first of the frame; capture det_idx=sample_idx; go to FRAME with frame_cnt=1. If packet_size==1, that sample carries tlast.
- State FRAME:
  - Forward raw samples and increment frame_cnt.
  - The sample where frame_cnt reaches packet_size carries tlast=1, except in select 2, where tlast is withheld.
  - Next state: INDEX for select 2, otherwise HOLDOFF.
  - tuser=1 here pulses det_missed and is otherwise ignored.
- State INDEX (select 2 only): emit one item, tdata=det_idx (zero-extended/truncated to ITEM_W), tlast=1. On its output handshake go to HOLDOFF.
- State HOLDOFF:
  - Handle samples as in IDLE for the latched select; holdoff_cnt counts input handshakes.
  - When holdoff_cnt==cfg_holdoff, go to IDLE. With cfg_holdoff=0, go directly to IDLE after the frame and skip HOLDOFF.
  - tuser=1 here pulses det_missed.
- Boundary cases:
  - A detection on the same handshake that exits HOLDOFF is missed (det_missed=1).
  - A tuser on a sample that is not handshaked is ignored.
  - With m_axis_tready held low, frame content is preserved sample-by-sample; nothing is dropped inside FRAME.
  - Mode change while in IDLE takes effect on the next input handshake.

Optional Feature:
- Macro SCHMIDL_COX_FRAME_CTRL_STATS_EN.
- When defined, adds outputs:
  - stat_frames (32): frames completed, counted at the tlast handshake.
  - stat_missed (32): det_missed pulses.
  - Both saturate at all-ones and clear on reset.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package schmidl_cox_pkg holds:
  - output_select enum (SEL_ZERO=0, SEL_FRAME=1, SEL_FRAME_IDX=2, SEL_BYPASS=3).
  - FSM state enum (IDLE, FRAME, INDEX, HOLDOFF).
  - Default widths.
- One sub-module: schmidl_cox_out_reg, the single-stage AXIS output register with the ready equation above.

Test Plan:
- select=1, packet_size=4, holdoff=0, tuser on sample 10 of a ramp 0..30 -> output exactly 10,11,12,13; tlast on 13; no other output.
- select=2, packet_size=3, tuser on sample_idx 100 -> output samples 100,101,102 then item 0x00000064 with tlast; tlast absent on 102.
- select=1, packet_size=4, holdoff=5, tuser at samples 10, 12 and 16 -> one frame 10..13; det_missed pulses for 12 and 16; tuser at 19 starts a new frame 19..22.
- select=0, no detection, 8 samples -> 8 zero items, tlast never asserted.
- select=3, packet_size=5, 12 samples -> raw passthrough; tlast on samples 4 and 9.
- select=1, packet_size=6, random m_axis_tready low 50% plus ce_rst_n pulse after 3 frame samples -> no lost or duplicated samples before reset; after reset tvalid=0, state IDLE, next tuser frames correctly.
